// File: rtl/vc_tag_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vc_tag_decoder
// Description : Decodes the VC id from each packet's head flit, rewrites it to
//               HEAD, and forwards the packet through one registered output
//               slot tagged one-hot per VC. Optional protocol checking is
//               enabled by defining the macro VC_TAG_CHECK_EN.
//               V/DW/HEAD/BODY/TAIL mirror params.vh and default to its values.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_tag_decoder #(
    parameter int         V    = 4,
    parameter int         DW   = 16,
    parameter logic [1:0] HEAD = 2'b00,
    parameter logic [1:0] BODY = 2'b01,
    parameter logic [1:0] TAIL = 2'b10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic [V-1:0]  valid_o,
    output logic [DW-1:0] data_o,
    input  logic [V-1:0]  ready_i,
    output logic [15:0]   pkt_cnt_o,
    output logic          error_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cur_vc_q, cur_vc_d;
    logic          buf_valid_q, buf_valid_d;
    logic [1:0]    buf_vc_q, buf_vc_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic          buf_tail_q, buf_tail_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic [1:0]    in_type;
    logic          sel_ready;
    logic          out_xfer;
    logic          accept;
    logic          unused_body_code;

    assign in_type          = data_i[DW-1:DW-2];
    assign unused_body_code = ^BODY;

    always_comb begin
        state_d    = state_q;
        cur_vc_d   = cur_vc_q;
        buf_valid_d = buf_valid_q;
        buf_vc_d   = buf_vc_q;
        buf_data_d = buf_data_q;
        buf_tail_d = buf_tail_q;
        pkt_cnt_d  = pkt_cnt_q;
        sel_ready  = 1'b0;
        valid_o    = '0;

        for (int i = 0; i < V; i++) begin
            if (buf_vc_q == 2'(i)) begin
                sel_ready  = ready_i[i];
                valid_o[i] = buf_valid_q;
            end
        end

        out_xfer = buf_valid_q && sel_ready;
        ready_o  = !buf_valid_q || sel_ready;
        accept   = valid_i && ready_o;

        if (out_xfer) begin
            buf_valid_d = 1'b0;
            // Only tails that closed a real packet count; heads never set the flag.
            if (buf_tail_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        if (accept) begin
            buf_valid_d = 1'b1;
            if (state_q == S_IDLE) begin
                buf_vc_d   = in_type;
                buf_data_d = {HEAD, data_i[DW-3:0]};
                buf_tail_d = 1'b0;
                cur_vc_d   = in_type;
                state_d    = S_PKT;
            end else begin
                buf_vc_d   = cur_vc_q;
                buf_data_d = data_i;
                buf_tail_d = (in_type == TAIL);
                if (in_type == TAIL) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cur_vc_q    <= 2'd0;
            buf_valid_q <= 1'b0;
            buf_vc_q    <= 2'd0;
            buf_data_q  <= '0;
            buf_tail_q  <= 1'b0;
            pkt_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            cur_vc_q    <= cur_vc_d;
            buf_valid_q <= buf_valid_d;
            buf_vc_q    <= buf_vc_d;
            buf_data_q  <= buf_data_d;
            buf_tail_q  <= buf_tail_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign data_o    = buf_data_q;
    assign pkt_cnt_o = pkt_cnt_q;

`ifdef VC_TAG_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (accept) begin
            if ((state_q == S_IDLE) && (32'(in_type) >= V)) begin
                error_d = 1'b1;
            end
            if ((state_q == S_PKT) && (in_type == HEAD)) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/vc_tag_decoder.md
VC_TAG_DECODER -- requirements
Module: vc_tag_decoder

Interface
REQ-001 SHALL take V, DW, HEAD, BODY, TAIL from params.vh; the flit type field is data[DW-1:DW-2].
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rstn  input  1  synchronous active-low reset.
REQ-005 valid_i  input  1  upstream flit valid.
REQ-006 data_i  input  DW  upstream flit; on a head flit the type field carries the binary VC id.
REQ-007 ready_o  output  1  flit accepted on this edge when valid_i && ready_o.
REQ-008 valid_o  output  V  one-hot per-VC valid of the registered output flit.
REQ-009 data_o  output  DW  registered output flit, shared by all VCs.
REQ-010 ready_i  input  V  per-VC downstream ready.
REQ-011 pkt_cnt_o  output  16  count of tail flits delivered downstream.
REQ-012 error_o  output  1  sticky protocol error (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE (next flit is a head) / PKT (inside a packet); packets are at least 2 flits, head..tail.
REQ-014 In IDLE, an accepted flit SHALL be treated as a head: vc = data_i[DW-1:DW-2]; type field rewritten to HEAD; rest of the flit unchanged; vc latched into cur_vc; next state PKT.
REQ-015 In PKT, an accepted flit SHALL be forwarded unmodified, tagged with cur_vc; a flit of type TAIL SHALL return the FSM to IDLE.
REQ-016 Single output register (buf_valid, buf_vc, buf_data); latency from accept to valid_o SHALL be exactly 1 cycle.
REQ-017 valid_o SHALL equal onehot(buf_vc) when buf_valid, else all zero.
REQ-018 Output transfer occurs when buf_valid && ready_i[buf_vc]; ready_i bits for other VCs SHALL be ignored.
REQ-019 ready_o SHALL be !buf_valid || ready_i[buf_vc] (combinational pass-through); zero-bubble streaming at 1 flit/cycle SHALL be supported.
REQ-020 Simultaneous output transfer and input accept SHALL load the new flit; transfer without accept SHALL clear buf_valid.
REQ-021 While buf_valid && !ready_i[buf_vc], buf_data/buf_vc SHALL hold stable.
REQ-022 pkt_cnt_o SHALL increment by 1 on each output transfer of a flit whose type is TAIL while in-packet, and wrap 16'hFFFF -> 0.
REQ-023 valid_i low SHALL not change FSM state; gaps inside a packet are legal.

Reset
REQ-024 On rstn low at a clock edge: FSM=IDLE, cur_vc=0, buf_valid=0, buf_vc=0, data_o=0, valid_o=0, pkt_cnt_o=0, error_o=0.
REQ-025 ready_o SHALL be 1 in the cycle after reset, since the output register is empty.
REQ-026 Reset mid-packet SHALL discard the partial packet; the first accepted flit after reset SHALL be decoded as a head.

Configuration
REQ-027 Macro VC_TAG_CHECK_EN SHALL enable protocol checking.
REQ-028 With VC_TAG_CHECK_EN: error_o SHALL set, and remain set until reset, when either of these occurs:
- an accepted IDLE flit carries a VC id >= V;
- an accepted PKT flit has type HEAD.
Flits SHALL still be forwarded as normal.
REQ-029 Without VC_TAG_CHECK_EN: error_o SHALL be constant 0 and no check logic is synthesised.

Verification (V=4)
REQ-030 Test 1, basic packet:
- stimulus: 3-flit packet, head type field 2'b10, then BODY, then TAIL; ready_i=4'b1111;
- required: valid_o=4'b0100 for 3 consecutive cycles, starting 1 cycle after the head; head data_o[DW-1:DW-2]=HEAD; pkt_cnt_o=1.
REQ-031 Test 2, backpressure:
- stimulus: VC id 2'b11, ready_i=4'b0111 held for 5 cycles;
- required: valid_o=4'b1000 with data_o stable; ready_o=0 while the register is full; flit drains in the cycle ready_i[3] rises.
REQ-032 Test 3, back-to-back packets:
- stimulus: packets on VC1 then VC0 with no idle cycle; valid_i continuous;
- required: valid_o sequence 0010,0010,0001,0001; ready_o constantly 1; pkt_cnt_o=2.
REQ-033 Test 4, reset mid-packet:
- stimulus: rstn low for 1 cycle after a head plus 1 body;
- required: outputs per REQ-024; the next flit, type 2'b01, is delivered on valid_o=4'b0010 with type rewritten to HEAD.
REQ-034 Test 5, protocol check, run with VC_TAG_CHECK_EN:
- stimulus: a HEAD-typed flit inside a packet;
- required: error_o=1 one cycle later, sticky.
- Without the macro, error_o=0 throughout.
REQ-035 Test 6, counter wrap:
- stimulus: preload by sending 65536 two-flit packets;
- required: pkt_cnt_o wraps to 0.
